// File: rtl/demux8_buffered.sv
// 1-to-8 steering block: one producer stream routed by in_sel to one of eight
// consumer lanes, each with a one-entry output register and its own handshake.
module demux8_buffered #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic [2:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [N-1:0] out_data0,
  output logic [N-1:0] out_data1,
  output logic [N-1:0] out_data2,
  output logic [N-1:0] out_data3,
  output logic [N-1:0] out_data4,
  output logic [N-1:0] out_data5,
  output logic [N-1:0] out_data6,
  output logic [N-1:0] out_data7,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic         busy,
  output logic [15:0]  xfer_count
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge.
  // Producer holds data/sel while valid is high until accepted; each lane holds
  // its data while out_valid[k] is high until out_ready[k] takes it.

  logic         in_fire;
  logic [7:0]   lane_valid;
  logic [N-1:0] lane_data [8];

  // Only the selected lane gates acceptance, so a stalled lane never blocks others.
  assign in_ready = !rst && !flush && (!lane_valid[in_sel] || out_ready[in_sel]);
  assign in_fire  = in_valid && in_ready;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic         v_q;
    logic [N-1:0] d_q;
    logic         wr;
    logic         drain;

    assign wr    = in_fire && (in_sel == 3'(k));
    assign drain = v_q && out_ready[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (wr) begin
        v_q <= 1'b1;
        d_q <= in_data;
      end else if (drain) begin
        v_q <= 1'b0;
      end
    end

    assign lane_valid[k] = v_q;
    assign lane_data[k]  = d_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (flush) begin
      xfer_count <= '0;
    end else if (in_fire) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

  assign out_valid = lane_valid;
  assign busy      = |lane_valid;
  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];
  assign out_data4 = lane_data[4];
  assign out_data5 = lane_data[5];
  assign out_data6 = lane_data[6];
  assign out_data7 = lane_data[7];

endmodule

// File: doc/demux8_buffered.md
Name: demux8_buffered

Overview:
- 1-to-8 steering block, the inverse of the CPU's 8-input result multiplexer: a single producer stream is routed to one of eight consumer lanes, chosen by a 3-bit select.
- Each lane has a one-entry output register with a valid/ready handshake, so one stalled consumer never blocks transfers to the other lanes.
- Sits between the execute/ALU result stage and downstream consumers: writeback ports, vector lanes, memory-store staging.

Parameters:
- N, 32, data width of the input and of every output lane.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N  producer data.
- in_sel  input  3  destination lane index 0..7.
- in_valid  input  1  producer has data this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- flush  input  1  synchronous clear of all lane buffers.
- out_data0 .. out_data7  output  N each  lane k data register.
- out_valid  output  8  bit k = lane k holds valid data.
- out_ready  input  8  bit k = consumer k takes data this cycle.
- busy  output  1  OR of out_valid.
- xfer_count  output  16  number of accepted input transfers since reset or flush, wrapping.

Behaviour:
- Reset (rst=1, asynchronous):
  - out_valid=8'h00, all out_dataK=0, xfer_count=0.
  - in_ready drops immediately, since it is gated by rst.
  - Any in-flight data is discarded.
- Lane state: each lane is either EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1). There are no other states.
- Input accept: in_fire = in_valid & in_ready.
- in_ready (combinational) = !rst & !flush & (!out_valid[in_sel] | out_ready[in_sel]).
  - The selected lane must be empty, or must be draining in the same cycle.
  - in_ready depends only on the selected lane.
- Output handshake: out_fire[k] = out_valid[k] & out_ready[k].
  - out_dataK must remain stable while out_valid[k]=1 and out_ready[k]=0.
- Per-lane next state at the rising edge:
  - in_fire and in_sel==k: out_dataK<=in_data and out_valid[k]<=1. This applies whether the lane was empty or draining, giving back-to-back full throughput.
  - else if out_fire[k]: out_valid[k]<=0, and out_dataK holds its old value.
  - else: no change.
- Latency: data accepted in cycle t is visible on out_dataK with out_valid[k]=1 in cycle t+1. There is no combinational path from in_data to out_dataK.
- Only one lane can be written per cycle. Any number of lanes may drain in the same cycle.
- flush (synchronous, highest priority after rst):
  - Next edge: all out_valid<=0 and xfer_count<=0.
  - in_ready=0 during flush, so no transfer is accepted.
  - out_dataK values are retained, but they are don't-care while their valid bit is low.
- xfer_count increments by 1 on each in_fire and wraps 16'hFFFF -> 16'h0000.
- busy = |out_valid, combinational from registered state.
- in_sel is don't-care when in_valid=0. in_ready is still evaluated for the current in_sel.
- Producer protocol: once in_valid=1, in_data and in_sel must not change until in_fire. An assertion in the bench checks this, not the RTL.

Test Plan:
- Reset mid-transfer: lane 3 full with data 0xDEADBEEF; assert rst asynchronously mid-cycle -> out_valid=0x00, out_data3=0, xfer_count=0 immediately, without waiting for a clock edge.
- Single route: in_sel=5, in_data=0x12345678, in_valid=1 for one cycle, out_ready=0x00 -> next cycle out_valid=0x20 and out_data5=0x12345678; with out_ready=0x20 asserted, out_valid returns to 0x00 on the following edge.
- Back-pressure isolation:
  - Lane 2 full with out_ready[2]=0; present in_sel=2 -> in_ready=0 and lane 2 holds its data.
  - Switch to in_sel=6 -> in_ready=1, lane 6 loads, lane 2 unchanged.
- Simultaneous fill and drain: lane 1 full with 0xA, out_ready[1]=1, in_sel=1, in_data=0xB -> in_ready=1; next cycle out_valid[1]=1 and out_data1=0xB. Stream 8 words this way -> 8 transfers in 8 cycles.
- Flush: lanes 0, 4 and 7 full (out_valid=0x91), xfer_count=3, flush=1 with in_valid=1 -> in_ready=0; next edge out_valid=0x00 and xfer_count=0.
- Counter wrap: preload 65535 accepted transfers, then one more in_fire -> xfer_count=0x0000. Also sweep in_sel 0..7 with random out_ready and check against a scoreboard with no loss, duplication or reorder per lane.
